// File: rtl/pipe_adder_if.sv
// Handshake/data bundle for pipe_adder: operand side (in_*, a, b, sub) and result side (out_*, sum, ovf).
// When PIPE_ADDER_SAT_EN is defined the bundle also carries the per-pair sat request.
interface pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
`ifdef PIPE_ADDER_SAT_EN
    logic             sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;
    logic             ovf;

`ifdef PIPE_ADDER_SAT_EN
    modport master (
        output in_valid, a, b, sub, sat, out_ready,
        input  in_ready, out_valid, sum, ovf
    );
    modport slave (
        input  in_valid, a, b, sub, sat, out_ready,
        output in_ready, out_valid, sum, ovf
    );
`else
    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, ovf
    );
    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, ovf
    );
`endif
endinterface

// File: rtl/pipe_adder.sv
// Elastic STAGES-deep add/subtract pipeline with valid/ready on both sides and a consumed-result counter.
// Optional signed saturation of the result is compiled in with PIPE_ADDER_SAT_EN.
module pipe_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    pipe_adder_if.slave bus,
    output logic [15:0] txn_cnt
);
    localparam int LAST = STAGES - 1;

    typedef struct packed {
        logic [WIDTH:0] sum;
        logic           ovf;
    } res_t;

    res_t              res_q [STAGES];
    res_t              res_d [STAGES];
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [15:0]       cnt_q;
    logic [15:0]       cnt_d;
    logic              in_rdy;

    // Subtraction is a + ~b + 1, so sum[WIDTH] reads as not-borrow.
    function automatic res_t add_sub(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y,
                                     input logic             is_sub);
        logic [WIDTH-1:0] y_op;
        res_t             r;
        y_op  = is_sub ? ~y : y;
        r.sum = {1'b0, x} + {1'b0, y_op} + {{WIDTH{1'b0}}, is_sub};
        r.ovf = (x[WIDTH-1] == y_op[WIDTH-1]) && (r.sum[WIDTH-1] != x[WIDTH-1]);
        return r;
    endfunction

`ifdef PIPE_ADDER_SAT_EN
    // On overflow both effective operands share a's sign, which picks the clamp direction.
    function automatic res_t saturate(input res_t r, input logic x_sign);
        res_t o;
        o = r;
        if (r.ovf) begin
            o.sum[WIDTH-1:0] = x_sign ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
        end
        return o;
    endfunction
`endif

    always_comb begin
        logic [STAGES:0]   free;
        logic [STAGES-1:0] adv;
        logic              accept;
        res_t              calc;

        free         = '0;
        adv          = '0;
        free[STAGES] = bus.out_ready;
        // A stage can take new data when it is empty or its contents move on this cycle.
        for (int k = LAST; k >= 0; k--) begin
            adv[k]  = vld_q[k] && free[k+1];
            free[k] = !vld_q[k] || adv[k];
        end

        in_rdy = reset && free[0];
        accept = bus.in_valid && in_rdy;

        calc = add_sub(bus.a, bus.b, bus.sub);
`ifdef PIPE_ADDER_SAT_EN
        if (bus.sat) begin
            calc = saturate(calc, bus.a[WIDTH-1]);
        end
`endif

        // Stage 0 boundary: capture of the computed result
        vld_d[0] = accept || (vld_q[0] && !adv[0]);
        res_d[0] = accept ? calc : res_q[0];

        // Stage k boundary: transfer from stage k-1
        for (int k = 1; k < STAGES; k++) begin
            vld_d[k] = adv[k-1] || (vld_q[k] && !adv[k]);
            res_d[k] = adv[k-1] ? res_q[k-1] : res_q[k];
        end

        cnt_d = cnt_q + 16'(adv[LAST]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            cnt_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                res_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
            res_q <= res_d;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = vld_q[LAST];
    assign bus.sum       = res_q[LAST].sum;
    assign bus.ovf       = res_q[LAST].ovf;
    assign txn_cnt       = cnt_q;
endmodule
